// File: rtl/dnn_mlp_engine.sv
// Two-layer 4-3-2 MLP inference engine. A single shared 8x8 signed multiplier
// does one MAC term per cycle: 12 cycles for layer 1, then 6 cycles for layer 2.
module dnn_mlp_engine #(
  parameter int SHIFT = 7,
  parameter int ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_flat,
  input  logic [95:0] w1_flat,
  input  logic [47:0] b1_flat,
  input  logic [47:0] w2_flat,
  input  logic [31:0] b2_flat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y_flat,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] H_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Y_MIN = -(ACC_W'(32768));

  state_t state_r, state_nx_s;

  logic [31:0] x_r;
  logic [23:0] h_r;
  logic [31:0] y_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [1:0]  outer_r;
  logic [1:0]  inner_r;
  logic        in_ready_r, busy_r, out_valid_r;

  logic              last_inner_s, last_outer_s;
  logic [3:0]        w1_idx_s;
  logic [2:0]        w2_idx_s;
  logic signed [7:0] mul_a_s, mul_b_s;
  logic signed [15:0] bias_s, prod_s;
  logic signed [ACC_W-1:0] base_s, sum_s, shifted_s;
  logic [7:0]        h_nx_s;
  logic [15:0]       y_nx_s;

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign y_flat    = y_r;

  // Loop-end detection; the inner/outer bounds differ between the two layers.
  always_comb begin
    last_inner_s = 1'b0;
    last_outer_s = 1'b0;
    if (state_r == L1) begin
      last_inner_s = (inner_r == 2'd3);
      last_outer_s = (outer_r == 2'd2);
    end else begin
      last_inner_s = (inner_r == 2'd2);
      last_outer_s = (outer_r == 2'd1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx_s = L1;
        else          state_nx_s = IDLE;
      end
      L1: begin
        if (last_inner_s && last_outer_s) state_nx_s = L2;
        else                              state_nx_s = L1;
      end
      L2: begin
        if (last_inner_s && last_outer_s) state_nx_s = OUT;
        else                              state_nx_s = L2;
      end
      OUT: begin
        if (out_ready) state_nx_s = IDLE;
        else           state_nx_s = OUT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Operand selection for the shared multiplier and the MAC/activation datapath.
  always_comb begin
    w1_idx_s = ({2'b00, inner_r} * 4'd3) + {2'b00, outer_r};
    w2_idx_s = {inner_r, outer_r[0]};
    mul_a_s  = 8'sd0;
    mul_b_s  = 8'sd0;
    bias_s   = 16'sd0;
    case (state_r)
      L1: begin
        mul_a_s = x_r[{inner_r, 3'b000} +: 8];
        mul_b_s = w1_flat[{w1_idx_s, 3'b000} +: 8];
        bias_s  = b1_flat[{outer_r, 4'b0000} +: 16];
      end
      L2: begin
        // h is in 0..127, so it is also a valid non-negative signed byte
        mul_a_s = h_r[{inner_r, 3'b000} +: 8];
        mul_b_s = w2_flat[{w2_idx_s, 3'b000} +: 8];
        bias_s  = b2_flat[{outer_r, 4'b0000} +: 16];
      end
      default: begin
        mul_a_s = 8'sd0;
        mul_b_s = 8'sd0;
        bias_s  = 16'sd0;
      end
    endcase
    prod_s = mul_a_s * mul_b_s;
    if (inner_r == 2'd0) base_s = {{(ACC_W-16){bias_s[15]}}, bias_s};
    else                 base_s = acc_r;
    sum_s     = base_s + {{(ACC_W-16){prod_s[15]}}, prod_s};
    shifted_s = sum_s >>> SHIFT;
    if (shifted_s[ACC_W-1])     h_nx_s = 8'd0;
    else if (shifted_s > H_MAX) h_nx_s = 8'd127;
    else                        h_nx_s = shifted_s[7:0];
    if (sum_s > Y_MAX)      y_nx_s = 16'h7fff;
    else if (sum_s < Y_MIN) y_nx_s = 16'h8000;
    else                    y_nx_s = sum_s[15:0];
  end

  // State register and registered handshake/status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      busy_r      <= (state_nx_s != IDLE);
      out_valid_r <= (state_nx_s == OUT);
    end
  end

  // Datapath: input latch, accumulator, loop counters, hidden and output stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r     <= 32'd0;
      h_r     <= 24'd0;
      y_r     <= 32'd0;
      acc_r   <= '0;
      outer_r <= 2'd0;
      inner_r <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_r     <= x_flat;
            outer_r <= 2'd0;
            inner_r <= 2'd0;
          end
        end
        L1, L2: begin
          acc_r <= sum_s;
          if (last_inner_s) begin
            inner_r <= 2'd0;
            if (state_r == L1) h_r[{outer_r, 3'b000} +: 8] <= h_nx_s;
            else               y_r[{outer_r, 4'b0000} +: 16] <= y_nx_s;
            if (last_outer_s) outer_r <= 2'd0;
            else              outer_r <= outer_r + 2'd1;
          end else begin
            inner_r <= inner_r + 2'd1;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_mlp_engine.sv
// Directed-vector bench for dnn_mlp_engine with hand-computed expected results.
module tb_dnn_mlp_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_flat;
  logic [95:0] w1_flat;
  logic [47:0] b1_flat;
  logic [47:0] w2_flat;
  logic [31:0] b2_flat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y_flat;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  dnn_mlp_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_flat(x_flat), .w1_flat(w1_flat), .b1_flat(b1_flat),
    .w2_flat(w2_flat), .b2_flat(b2_flat), .out_valid(out_valid),
    .out_ready(out_ready), .y_flat(y_flat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_x(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [31:0] pack_y(input int y0, input int y1);
    return {16'(y1), 16'(y0)};
  endfunction

  task automatic load_default_weights();
    int w1v [12] = '{26, 58, -2, 22, 15, -40, 1, -53, 27, -59, -16, -61};
    int w2v [6]  = '{63, 44, 13, 36, -1, -15};
    for (int k = 0; k < 12; k++) w1_flat[8*k +: 8] = 8'(w1v[k]);
    for (int k = 0; k < 6; k++)  w2_flat[8*k +: 8] = 8'(w2v[k]);
    b1_flat = {16'(-42), 16'(-2), 16'(5)};
    b2_flat = {16'(-47), 16'(59)};
  endtask

  // Accept one vector, optionally poke in_valid while busy and stall out_ready,
  // check latency and result, then complete the handshake.
  task automatic run_vector(input string tag, input logic [31:0] x, input logic [31:0] exp_y,
                            input bit noise, input bit stall);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    x_flat   = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy"}, {30'd0, busy, in_ready}, 32'd2);
    if (noise) x_flat = pack_x(-7, 99, 3, -100);
    else       in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd18);
    check({tag, "_y"}, y_flat, exp_y);
    if (stall) begin
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        #1;
        check({tag, "_stall_y"}, y_flat, exp_y);
        check({tag, "_stall_flags"}, {29'd0, out_valid, in_ready, busy}, 32'd5);
      end
      in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_flags"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
    check({tag, "_y_retained"}, y_flat, exp_y);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x_flat = 32'd0;
    load_default_weights();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_flags", {29'd0, out_valid, in_ready, busy}, 32'd2);
    check("reset_y", y_flat, 32'd0);

    run_vector("zero", pack_x(0, 0, 0, 0), pack_y(59, -47), 1'b0, 1'b0);
    run_vector("x100", pack_x(100, 0, 0, 0), pack_y(1904, 2453), 1'b0, 1'b0);
    run_vector("mixed", pack_x(127, 127, -128, -128), pack_y(8325, 9145), 1'b1, 1'b1);

    // Abort in the middle of layer 1.
    @(negedge clk);
    x_flat = pack_x(100, 0, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_flags", {29'd0, out_valid, in_ready, busy}, 32'd2);
    check("abort_y", y_flat, 32'd0);
    begin
      bit seen = 1'b0;
      repeat (25) begin
        @(posedge clk);
        #1;
        if (out_valid) seen = 1'b1;
      end
      check("abort_no_valid", 32'(seen), 32'd0);
    end
    run_vector("after_abort", pack_x(0, 0, 0, 0), pack_y(59, -47), 1'b0, 1'b0);

    // Saturation: all weights 127, b1=0, b2=32767.
    w1_flat = {12{8'd127}};
    w2_flat = {6{8'd127}};
    b1_flat = 48'd0;
    b2_flat = {2{16'd32767}};
    run_vector("sat", pack_x(127, 127, 127, 127), pack_y(32767, 32767), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
